// File: rtl/inst_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin instance arbiter.
// Imported by the interface, the rr_pick search and the top.
package inst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int NUM_REQ_DEFAULT  = 15;
    localparam int MAX_HOLD_DEFAULT = 16;

    // Index width that stays legal even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inst_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface inst_rr_arbiter_if
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              gnt;
    logic                            gnt_valid;
    logic [id_width(NUM_REQ)-1:0]    gnt_id;
    logic                            timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );
endinterface

// File: rtl/inst_rr_arbiter_rr_pick.sv
// Rotating priority search: first active request after last_id, wrapping to 0.
module rr_pick
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] cand;

    // Offset 1 first so the previous winner is considered last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_id) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and IDLE/GRANT/GAP FSM.
// Define INST_ARB_TIMEOUT_EN to revoke grants after MAX_HOLD cycles.
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    inst_rr_arbiter_if.slave    bus
);

    localparam int ID_W = id_width(NUM_REQ);

    arb_state_t          state, state_next;
    logic [ID_W-1:0]     last_id, last_id_next;
    logic [ID_W-1:0]     gnt_id_r, gnt_id_next;
    logic [NUM_REQ-1:0]  gnt_r, gnt_next;
    logic                gnt_valid_r, gnt_valid_next;
    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic                holder_req;
    logic                hold_expired;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (bus.req),
        .last_id (last_id),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign holder_req = bus.req[gnt_id_r];

`ifdef INST_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout_r;
    logic              timeout_next;

    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign timeout_next = (state == GRANT) && holder_req && hold_expired;

    // Counter is zero on the first grant cycle, so expiry lands on cycle MAX_HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_next;
            if (state == GRANT && state_next == GRANT)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    assign bus.timeout = timeout_r;
`else
    localparam logic TIMEOUT_TIE = (MAX_HOLD == 0) & 1'b0;

    assign hold_expired = 1'b0;
    assign bus.timeout  = TIMEOUT_TIE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= ID_W'(NUM_REQ - 1);
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
        end else begin
            state       <= state_next;
            last_id     <= last_id_next;
            gnt_r       <= gnt_next;
            gnt_valid_r <= gnt_valid_next;
            gnt_id_r    <= gnt_id_next;
        end
    end

    // Grant outputs are computed here and registered, so they are 0 outside GRANT.
    always_comb begin
        state_next     = state;
        last_id_next   = last_id;
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        gnt_id_next    = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    gnt_next       = NUM_REQ'(1) << pick_idx;
                    gnt_valid_next = 1'b1;
                    gnt_id_next    = pick_idx;
                    last_id_next   = pick_idx;
                end
            end
            GRANT: begin
                if (!holder_req || hold_expired) begin
                    state_next = GAP;
                end else begin
                    gnt_next       = gnt_r;
                    gnt_valid_next = 1'b1;
                    gnt_id_next    = gnt_id_r;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Self-checking bench for inst_rr_arbiter against a cycle-level behavioural model.
module tb_inst_rr_arbiter;
    import inst_arb_pkg::*;

    localparam int N        = 15;
    localparam int MAX_HOLD = 16;
`ifdef INST_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    inst_rr_arbiter_if #(.NUM_REQ(N)) bus ();

    inst_rr_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1 = granting, 2 = gap.
    int         m_phase;
    int         m_last;
    int         m_holder;
    int         m_held;
    logic [N-1:0] exp_gnt;
    logic [3:0]   exp_id;
    logic         exp_valid;
    logic         exp_to;

    task automatic model_reset();
        m_phase   = 0;
        m_last    = N - 1;
        m_holder  = 0;
        m_held    = 0;
        exp_gnt   = '0;
        exp_id    = '0;
        exp_valid = 1'b0;
        exp_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        exp_to = 1'b0;
        if (m_phase == 0) begin
            if (r != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (r[(m_last + k) % N]) begin
                        m_holder = (m_last + k) % N;
                        break;
                    end
                end
                m_last    = m_holder;
                m_phase   = 1;
                m_held    = 1;
                exp_gnt   = '0;
                exp_gnt[m_holder] = 1'b1;
                exp_id    = 4'(m_holder);
                exp_valid = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (!r[m_holder] || (TO_EN && m_held == MAX_HOLD)) begin
                exp_to    = r[m_holder];
                m_phase   = 2;
                exp_gnt   = '0;
                exp_id    = '0;
                exp_valid = 1'b0;
            end else begin
                m_held++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] r);
        @(negedge clk);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== '0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold gnt=%h valid=%b id=%0d to=%b expected all zero",
                     bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step('0);
            checks++;
            if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== '0) begin
                failures++;
                $display("[TB] FAIL idle_after_reset cyc=%0d gnt=%h valid=%b id=%0d expected 0",
                         c, bus.gnt, bus.gnt_valid, bus.gnt_id);
            end
        end
    endtask

    task automatic test_single();
        int high_cycles;
        logic [N-1:0] r;
        high_cycles = 0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            r = (c < 5) ? N'(1) : '0;
            step(r);
            if (bus.gnt === N'(1)) high_cycles++;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                failures++;
                $display("[TB] FAIL single_gnt cyc=%0d got=%h exp=%h", c, bus.gnt, exp_gnt);
            end
            checks++;
            if (bus.gnt_valid !== exp_valid || bus.gnt_id !== exp_id) begin
                failures++;
                $display("[TB] FAIL single_id cyc=%0d got=%b/%0d exp=%b/%0d",
                         c, bus.gnt_valid, bus.gnt_id, exp_valid, exp_id);
            end
        end
        checks++;
        if (high_cycles != 5) begin
            failures++;
            $display("[TB] FAIL single_len got=%0d exp=5", high_cycles);
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        logic prev_valid;
        logic [N-1:0] r;
        prev_valid = 1'b0;
        apply_reset();
        for (int c = 0; c < 200 && seq.size() < 16; c++) begin
            r = {N{1'b1}};
            if (m_phase == 1 && m_held == 2) r[m_holder] = 1'b0;
            step(r);
            if (bus.gnt_valid === 1'b1 && !prev_valid) seq.push_back(int'(bus.gnt_id));
            prev_valid = bus.gnt_valid;
            checks++;
            if (bus.gnt !== exp_gnt || bus.gnt_id !== exp_id || bus.gnt_valid !== exp_valid) begin
                failures++;
                $display("[TB] FAIL rr_cycle cyc=%0d got=%h/%0d exp=%h/%0d",
                         c, bus.gnt, bus.gnt_id, exp_gnt, exp_id);
            end
        end
        checks++;
        if (seq.size() != 16) begin
            failures++;
            $display("[TB] FAIL rr_count got=%0d grants exp=16", seq.size());
        end
        for (int k = 0; k < seq.size(); k++) begin
            checks++;
            if (seq[k] != k % N) begin
                failures++;
                $display("[TB] FAIL rr_order grant=%0d got=%0d exp=%0d", k, seq[k], k % N);
            end
        end
    endtask

    task automatic test_wrap();
        int seq[$];
        logic prev_valid;
        logic [N-1:0] r;
        apply_reset();
        step(N'(1));
        step('0);
        step('0);
        prev_valid = 1'b0;
        for (int c = 0; c < 40 && seq.size() < 2; c++) begin
            r = 15'h4001;
            if (m_phase == 1 && m_held == 2) r[m_holder] = 1'b0;
            step(r);
            if (bus.gnt_valid === 1'b1 && !prev_valid) seq.push_back(int'(bus.gnt_id));
            prev_valid = bus.gnt_valid;
        end
        checks++;
        if (seq.size() != 2 || seq[0] != 14 || seq[1] != 0) begin
            failures++;
            $display("[TB] FAIL wrap_order got=%p exp='{14,0}", seq);
        end
    endtask

    task automatic test_hold();
        int to_count;
        int high_cycles;
        int exp_to_count;
        int exp_high;
        to_count     = 0;
        high_cycles  = 0;
        exp_to_count = TO_EN ? 2 : 0;
        exp_high     = TO_EN ? 36 : 40;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            step(15'h0004);
            if (bus.timeout === 1'b1) to_count++;
            if (bus.gnt === 15'h0004) high_cycles++;
            checks++;
            if (bus.gnt !== exp_gnt || bus.timeout !== exp_to) begin
                failures++;
                $display("[TB] FAIL hold_cycle cyc=%0d got=%h/%b exp=%h/%b",
                         c, bus.gnt, bus.timeout, exp_gnt, exp_to);
            end
        end
        checks++;
        if (to_count != exp_to_count || high_cycles != exp_high) begin
            failures++;
            $display("[TB] FAIL hold_totals got=%0d/%0d exp=%0d/%0d",
                     to_count, high_cycles, exp_to_count, exp_high);
        end
        step('0);
        step('0);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom) & N'($urandom);
            if (m_phase == 1) r[m_holder] = ($urandom_range(0, 9) != 0);
            step(r);
            checks++;
            if (bus.gnt !== exp_gnt || bus.gnt_id !== exp_id) begin
                failures++;
                $display("[TB] FAIL rand_gnt cyc=%0d got=%h/%0d exp=%h/%0d",
                         c, bus.gnt, bus.gnt_id, exp_gnt, exp_id);
            end
            checks++;
            if (bus.gnt_valid !== exp_valid || bus.timeout !== exp_to || $countones(bus.gnt) > 1) begin
                failures++;
                $display("[TB] FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b",
                         c, bus.gnt_valid, bus.timeout, exp_valid, exp_to);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        step(15'h0080);
        step(15'h0080);
        step(15'h0080);
        checks++;
        if (bus.gnt !== 15'h0080 || bus.gnt_id !== 4'd7) begin
            failures++;
            $display("[TB] FAIL mid_setup got=%h/%0d exp=0080/7", bus.gnt, bus.gnt_id);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== '0) begin
            failures++;
            $display("[TB] FAIL mid_async got=%h/%b/%0d exp=0/0/0",
                     bus.gnt, bus.gnt_valid, bus.gnt_id);
        end
        bus.req = 15'h0A48;
        @(negedge clk);
        rst = 1'b0;
        step(15'h0A48);
        checks++;
        if (bus.gnt !== exp_gnt || bus.gnt_id !== 4'd3) begin
            failures++;
            $display("[TB] FAIL mid_regrant got=%h/%0d exp=%h/3", bus.gnt, bus.gnt_id, exp_gnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hold();
        test_random();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
